cdc_event_queue: RTL
====================

# cdc_event_queue

Single-clock event accumulator that sits directly upstream of the clock-domain-crossing event buffer, on its source side. It accepts single-cycle event pulses on any cycle and counts them in a saturating pending counter. It then replays them one at a time as single-cycle requests, issuing each only while the crossing reports ready. Bursts that arrive faster than the crossing can hand over are therefore never lost, up to the counter capacity.

## Interface
- CNT_W, default 8: width of the pending-event counter; capacity 2^CNT_W-1 events; legal range 2..16.
- clk_i  input  1  source-domain clock; all logic on its rising edge.
- rst_i  input  1  reset, asynchronous assert, active-low.
- event_i  input  1  event pulse; every high cycle counts as one event.
- clear_i  input  1  synchronous flush: discards pending events and clears flags.
- req_o  output  1  request pulse to the crossing's source request input.
- ready_i  input  1  ready from the crossing's source ready output.
- pending_o  output  CNT_W  current pending count.
- overflow_o  output  1  sticky: an event was dropped at saturation.
- dropCnt_o  output  CNT_W  dropped-event count (see Configuration).

## Operation
- Reset values: req_o=0, pending_o=0, overflow_o=0, dropCnt_o=0, state IDLE.
- FSM states and transitions:
  - IDLE to ISSUE when ready_i=1 and pending>0.
  - ISSUE lasts exactly one cycle, with req_o=1. It always moves to WAIT.
  - WAIT to IDLE when ready_i=0. This guards against a ready that lags the request by one or more cycles.
  - WAIT also goes to IDLE after 4 consecutive cycles with ready_i=1. A crossing that drops ready for less than one of our cycles is not missed; the 2-bit counter for this is cleared on entering WAIT.
- req_o is a registered output. It is high only in ISSUE, and ISSUE is entered only from a cycle where ready_i=1.
- Counter update per cycle: next = pending + inc - dec.
  - inc = event_i and not saturated.
  - dec = 1 in the cycle the FSM enters ISSUE.
  - With simultaneous inc and dec, the count is unchanged.
- Saturation: when pending = 2^CNT_W-1, event_i=1 and dec=0, the event is dropped and overflow_o is set. If dec=1 in that same cycle, the event is accepted and nothing is dropped.
- clear_i has priority over everything:
  - pending, overflow_o and dropCnt_o go to 0 and the FSM goes to IDLE.
  - An ISSUE already registered still completes its single req_o cycle.
  - event_i in the same cycle as clear_i is discarded.
- Reset mid-operation: all state clears immediately. No request is reissued for events pending at reset.

## Timing
- Throughput: at most one request per 3 cycles (ISSUE, WAIT with at least one cycle, IDLE).
- Latency: event_i high in cycle N with pending=0 and ready_i=1 gives pending_o=1 in N+1 and req_o=1 in N+2.
- pending_o reflects the decrement in the same cycle req_o rises.
- No combinational path from any input to any output.

## Configuration
- CDC_EVENT_QUEUE_DROPCNT_EN
  - Defined: dropCnt_o counts dropped events, saturating at 2^CNT_W-1, cleared by reset or clear_i.
  - Undefined: dropCnt_o is tied to 0 and no counter register is built. overflow_o behaves identically either way.

## Structure
- Package cdc_event_queue_pkg holds:
  - the FSM state enum: IDLE, ISSUE, WAIT;
  - the WAIT timeout constant (4).
- One sub-module, sat_counter, is natural: parameterised width, with inc, dec, clear, a saturated flag and a drop strobe. It is used for both the pending count and the drop count.
- The crossing itself is instantiated by the parent, not inside this block.

## Test plan
- Single event: event_i pulse at cycle 0 with ready_i=1 → req_o high for exactly cycle 2. pending_o reads 1 in cycle 1 and 0 from cycle 2. ready_i driven low cycles 3–6 → no further req_o.
- Burst: event_i high for 5 consecutive cycles while ready_i falls 1 cycle after each req_o and recovers 3 cycles later → exactly 5 req_o pulses, never with ready_i=0, pending_o ending at 0.
- Saturation with CNT_W=2: 5 events while ready_i=0 → pending_o=3, overflow_o=1, dropCnt_o=2 with the macro defined (0 without). Then ready_i=1 → exactly 3 requests.
- Simultaneous: event_i=1 in the same cycle the FSM enters ISSUE, with pending=3 and CNT_W=2 → pending stays 3, no drop, overflow_o stays 0.
- Clear and reset: clear_i with pending=4 and event_i=1 → pending_o=0 next cycle and no new req_o. Async rst_i low mid-WAIT → all outputs 0 within the same cycle.
- Stuck ready: ready_i held 1 throughout, 2 events → second req_o appears after the 4-cycle WAIT timeout plus one IDLE cycle.

Source files
------------

// File: rtl/cdc_event_queue_pkg.sv
// Shared types and constants for the cdc_event_queue block.
package cdc_event_queue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // WAIT exits after this many consecutive cycles with ready high.
    localparam int          WAIT_TIMEOUT = 4;
    localparam logic [1:0]  WAIT_LAST    = 2'(WAIT_TIMEOUT - 1);

endpackage

// File: rtl/cdc_event_queue_sat.sv
// Saturating up/down counter: a simultaneous inc+dec at saturation is accepted,
// an inc with no dec at saturation is dropped and reported on drop_o.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         clear_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o,
    output logic         drop_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         accept;

    assign sat_o  = &cnt_q;
    assign accept = inc_i && (!sat_o || dec_i);
    assign drop_o = inc_i && !accept && !clear_i;
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (accept && !dec_i)
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && !accept && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cdc_event_queue.sv
// Source-side event accumulator feeding a CDC event buffer; replays pending
// events as single-cycle requests. Optional drop counter: CDC_EVENT_QUEUE_DROPCNT_EN.
module cdc_event_queue
    import cdc_event_queue_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             event_i,
    input  logic             clear_i,
    output logic             req_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] dropCnt_o
);

    state_e     state_q, state_d;
    logic [1:0] run_q, run_d;
    logic       req_q, req_d;
    logic       ovf_q, ovf_d;
    logic       start;
    logic       pend_sat, pend_drop;

    assign start = (state_q == IDLE) && ready_i && (pending_o != '0) && !clear_i;

    sat_counter #(.W(CNT_W)) u_pending (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (event_i),
        .dec_i   (start),
        .clear_i (clear_i),
        .cnt_o   (pending_o),
        .sat_o   (pend_sat),
        .drop_o  (pend_drop)
    );

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        req_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = ISSUE;
                req_d   = 1'b1;
            end
            ISSUE: begin
                state_d = WAIT;
                run_d   = '0;
            end
            // Leave on any low ready, or after a full run of high ready in
            // case the crossing's ready dip was too short for us to see.
            WAIT: begin
                if (!ready_i || run_q == WAIT_LAST) state_d = IDLE;
                else                                run_d   = run_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end
    end

    assign ovf_d = clear_i ? 1'b0 : (ovf_q | pend_drop);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            run_q   <= '0;
            req_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            req_q   <= req_d;
            ovf_q   <= ovf_d;
        end
    end

    assign req_o      = req_q;
    assign overflow_o = ovf_q;

`ifdef CDC_EVENT_QUEUE_DROPCNT_EN
    logic drop_sat, drop_drop;

    sat_counter #(.W(CNT_W)) u_dropcnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (pend_drop),
        .dec_i   (1'b0),
        .clear_i (clear_i),
        .cnt_o   (dropCnt_o),
        .sat_o   (drop_sat),
        .drop_o  (drop_drop)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, pend_sat, drop_sat, drop_drop};
`else
    assign dropCnt_o = '0;

    logic unused_ok;
    assign unused_ok = &{1'b0, pend_sat};
`endif

endmodule
